cmd_arbiter: RTL and testbench
==============================

Name: cmd_arbiter

Overview:
- Merges two command sources into one ordered, rate-limited command stream for the mode/time controllers: UART RX bytes from the PC and debounced front-panel button pulses.
- Validates and normalises each command to an upper-case ASCII code ('M' 0x4D mode, 'H' 0x48 hour/min view, 'R' 0x52 run/stop, 'C' 0x43 clear).
- Arbitrates round-robin between the two sources into a small FIFO.
- Issues commands downstream over a valid/ready handshake, with a minimum gap between issued commands.

Parameters:
- DEPTH, 4, FIFO entries; power of two, range 2..16.
- GAP_CYC, 8, idle cycles forced after each issued command before the next out_valid; 0 disables the gap.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- rx_data  in  8  UART received byte.
- rx_done  in  1  1-cycle strobe; rx_data valid this cycle.
- btn_mode  in  1  1-cycle debounced pulse.
- btn_time  in  1  1-cycle debounced pulse.
- btn_run  in  1  1-cycle debounced pulse.
- btn_clear  in  1  1-cycle debounced pulse.
- out_data  out  8  issued command code; 0x00 when out_valid=0.
- out_valid  out  1  command available.
- out_ready  in  1  consumer accepts; transfer when out_valid&&out_ready.
- fifo_full  out  1  FIFO holds DEPTH entries.
- drop_cnt  out  CNT_W  saturating count of discarded commands.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; both holding registers empty.
  - RR pointer = UART; gap_cnt = 0.
  - Outputs: out_valid=0, out_data=0x00, fifo_full=0, drop_cnt=0.
  - Reset mid-transfer discards all queued and held commands.
- UART decode, on rx_done:
  - 0x4D/0x6D→'M', 0x48/0x68→'H', 0x52/0x72→'R', 0x43/0x63→'C'.
  - Any other byte is ignored silently and does not count as a drop.
- Button decode:
  - btn_mode→'M', btn_time→'H', btn_run→'R', btn_clear→'C'.
  - Several pulses in one cycle: fixed priority mode>time>run>clear. The winner is held; each loser increments drop_cnt (the counter advances by the number of losers, saturating).
- Holding registers:
  - One 1-entry register per source, loaded at the clock edge where the valid event is sampled.
  - New event while the register is still occupied: the new event is dropped, drop_cnt+1; the held value is kept.
- Arbiter:
  - Each cycle, if FIFO not full and at least one hold register is occupied, grant one source.
  - Both occupied: grant the source the RR pointer names, then flip the pointer to the other source.
  - Single requester: grant it; the pointer still flips to the other source.
  - The granted entry is written to the FIFO and its hold register is cleared at the same edge.
  - FIFO full: no grant; hold registers keep their contents (back-pressure; no drop at this stage).
- FIFO:
  - Synchronous, DEPTH entries, strict order.
  - Simultaneous write and read when full is legal: the read frees the slot the same cycle, so fifo_full and drop behaviour use the post-read count.
- Issue / gap scheduler:
  - out_valid = FIFO non-empty && gap_cnt==0. out_data = FIFO head when valid, else 0x00.
  - On transfer: pop the FIFO and load gap_cnt=GAP_CYC. gap_cnt decrements to 0 each cycle.
  - out_valid/out_data hold stable while out_ready=0.
- Latency: event sampled at edge N → hold at N → FIFO write at N+1 → out_valid high after edge N+1 (2 cycles), provided the FIFO was empty and gap_cnt=0.
- drop_cnt saturates at 2^CNT_W−1; no wrap.

Decomposition:
- Shared package: command code constants CMD_MODE=0x4D, CMD_TIME=0x48, CMD_RUN=0x52, CMD_CLEAR=0x43, CMD_NONE=0x00. The existing mode/time controllers use the same constants.
- One sub-module: cmd_fifo (parameterised DEPTH×8 synchronous FIFO with full/empty flags).
- Decode, arbitration and gap counter stay in the top.

Test Plan:
- Reset, then rx_done with rx_data=0x6D, out_ready=1 → out_valid high 2 cycles later with out_data=0x4D. Next command blocked for 8 cycles (GAP_CYC=8).
- rx_done 0x48 and btn_run in the same cycle, FIFO empty → issue order 0x48 then 0x52 (RR starts at UART). Repeat the same stimulus → 0x52 then 0x48.
- btn_mode and btn_clear pulsed together → only 0x4D queued; drop_cnt=1.
- out_ready=0; send 6 valid UART commands spaced 2 cycles apart → fifo_full=1 after 4. The 5th stays held. The 6th arrives while the hold is occupied and is dropped (drop_cnt+1). Releasing out_ready drains 5 commands in order.
- rx_data=0x41 ('A') with rx_done → no out_valid; drop_cnt unchanged.
- Assert rst=0 asynchronously with 3 entries queued and out_valid=1 → out_valid=0, out_data=0x00 and drop_cnt=0 immediately, without waiting for a clock edge. After release, no stale command is issued.

Source files
------------

// File: rtl/cmd_arbiter_pkg.sv
// Shared command codes and helpers for the command arbiter and the controllers it feeds.
package cmd_arbiter_pkg;

  localparam logic [7:0] CMD_MODE  = 8'h4D;
  localparam logic [7:0] CMD_TIME  = 8'h48;
  localparam logic [7:0] CMD_RUN   = 8'h52;
  localparam logic [7:0] CMD_CLEAR = 8'h43;
  localparam logic [7:0] CMD_NONE  = 8'h00;

  typedef enum logic {
    SrcUart = 1'b0,
    SrcBtn  = 1'b1
  } src_e;

  // Map a received byte to its upper-case command code; CMD_NONE for anything unknown.
  function automatic logic [7:0] uart_decode(input logic [7:0] b);
    logic [7:0] code;
    case (b)
      8'h4D, 8'h6D: code = CMD_MODE;
      8'h48, 8'h68: code = CMD_TIME;
      8'h52, 8'h72: code = CMD_RUN;
      8'h43, 8'h63: code = CMD_CLEAR;
      default:      code = CMD_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/cmd_arbiter_fifo.sv
// Synchronous DEPTH x WIDTH FIFO; a write while full is accepted when a read frees a slot.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_rd, do_wr;

  // Qualify requests against the current occupancy.
  always_comb begin
    full    = (count_q == (AW + 1)'(DEPTH));
    empty   = (count_q == '0);
    do_rd   = rd_en && !empty;
    do_wr   = wr_en && (!full || do_rd);
    rd_data = mem_q[rd_ptr_q];
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// Merges UART and button commands into one ordered, gap-limited command stream.
module cmd_arbiter
  import cmd_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned GAP_CYC = 8,
  parameter int unsigned CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_done,
  input  logic             btn_mode,
  input  logic             btn_time,
  input  logic             btn_run,
  input  logic             btn_clear,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fifo_full,
  output logic [CNT_W-1:0] drop_cnt
);

  // +2 keeps the width non-zero when the gap is disabled.
  localparam int unsigned GapW = $clog2(GAP_CYC + 2);
  localparam logic [CNT_W+2:0] DropMax = {3'b000, {CNT_W{1'b1}}};

  logic [7:0]       uart_cmd, btn_cmd, uart_hold_q, btn_hold_q, fifo_wdata, fifo_rdata;
  logic             uart_evt, btn_evt, uart_full_q, btn_full_q;
  logic             grant_uart, grant_btn, can_write, pop, fifo_empty;
  logic             uart_drop, btn_drop;
  logic [2:0]       btn_hits, btn_losers, drop_inc;
  logic [CNT_W+2:0] drop_sum;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  src_e             rr_q, rr_d;

  // Decode both sources; buttons resolve by fixed priority mode > time > run > clear.
  always_comb begin
    uart_cmd = uart_decode(rx_data);
    uart_evt = rx_done && (uart_cmd != CMD_NONE);
    btn_cmd  = CMD_NONE;
    if (btn_mode)       btn_cmd = CMD_MODE;
    else if (btn_time)  btn_cmd = CMD_TIME;
    else if (btn_run)   btn_cmd = CMD_RUN;
    else if (btn_clear) btn_cmd = CMD_CLEAR;
    btn_evt    = btn_mode || btn_time || btn_run || btn_clear;
    btn_hits   = {2'b00, btn_mode} + {2'b00, btn_time} + {2'b00, btn_run} + {2'b00, btn_clear};
    btn_losers = btn_evt ? (btn_hits - 3'd1) : 3'd0;
  end

  // Issue side: head is offered only once the gap has expired.
  always_comb begin
    out_valid = !fifo_empty && (gap_cnt_q == '0);
    out_data  = out_valid ? fifo_rdata : CMD_NONE;
    pop       = out_valid && out_ready;
    drop_cnt  = drop_cnt_q;
    gap_cnt_d = gap_cnt_q;
    if (pop)                   gap_cnt_d = GapW'(GAP_CYC);
    else if (gap_cnt_q != '0)  gap_cnt_d = gap_cnt_q - 1'b1;
  end

  // Round-robin grant into the FIFO; a same-cycle pop makes room for the write.
  always_comb begin
    can_write  = !fifo_full || pop;
    grant_uart = 1'b0;
    grant_btn  = 1'b0;
    if (can_write) begin
      if (uart_full_q && btn_full_q) begin
        grant_uart = (rr_q == SrcUart);
        grant_btn  = (rr_q == SrcBtn);
      end else begin
        grant_uart = uart_full_q;
        grant_btn  = btn_full_q;
      end
    end
    rr_d = rr_q;
    if (grant_uart)     rr_d = SrcBtn;
    else if (grant_btn) rr_d = SrcUart;
    fifo_wdata = grant_uart ? uart_hold_q : btn_hold_q;
  end

  // Drop accounting; a hold register emptied by a grant at this edge can take a new event.
  always_comb begin
    uart_drop = uart_evt && uart_full_q && !grant_uart;
    btn_drop  = btn_evt && btn_full_q && !grant_btn;
    drop_inc  = btn_losers + {2'b00, uart_drop} + {2'b00, btn_drop};
    drop_sum  = {3'b000, drop_cnt_q} + {{CNT_W{1'b0}}, drop_inc};
    drop_cnt_d = (drop_sum > DropMax) ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  // Hold registers, round-robin pointer, gap counter and drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      uart_full_q <= 1'b0;
      uart_hold_q <= CMD_NONE;
      btn_full_q  <= 1'b0;
      btn_hold_q  <= CMD_NONE;
      rr_q        <= SrcUart;
      gap_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      if (uart_evt && (!uart_full_q || grant_uart)) begin
        uart_full_q <= 1'b1;
        uart_hold_q <= uart_cmd;
      end else if (grant_uart) begin
        uart_full_q <= 1'b0;
      end
      if (btn_evt && (!btn_full_q || grant_btn)) begin
        btn_full_q <= 1'b1;
        btn_hold_q <= btn_cmd;
      end else if (grant_btn) begin
        btn_full_q <= 1'b0;
      end
      rr_q       <= rr_d;
      gap_cnt_q  <= gap_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (grant_uart || grant_btn),
    .wr_data (fifo_wdata),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_cmd_arbiter.sv
// Directed bench for cmd_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_cmd_arbiter;

  localparam int WaitMax = 60;

  logic       clk, rst;
  logic [7:0] rx_data;
  logic       rx_done, btn_mode, btn_time, btn_run, btn_clear;
  logic [7:0] out_data;
  logic       out_valid, out_ready, fifo_full;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  cmd_arbiter #(
    .DEPTH   (4),
    .GAP_CYC (8),
    .CNT_W   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .btn_mode  (btn_mode),
    .btn_time  (btn_time),
    .btn_run   (btn_run),
    .btn_clear (btn_clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_full (fifo_full),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0; rx_data = 8'h00; rx_done = 1'b0; out_ready = 1'b0;
    btn_mode = 1'b0; btn_time = 1'b0; btn_run = 1'b0; btn_clear = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_data = b; rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  // Bits: {mode, time, run, clear}.
  task automatic pulse_btn(input logic [3:0] b);
    {btn_mode, btn_time, btn_run, btn_clear} = b;
    @(negedge clk);
    {btn_mode, btn_time, btn_run, btn_clear} = 4'b0000;
  endtask

  // Count falling edges with out_valid low, up to WaitMax.
  task automatic wait_valid(output int lows);
    lows = 0;
    while (lows < WaitMax && !out_valid) begin
      lows++;
      @(negedge clk);
    end
  endtask

  // Take the next issued command (out_ready must be high).
  task automatic get_cmd(output logic [7:0] d, output logic ok);
    int lows;
    wait_valid(lows);
    ok = (lows < WaitMax);
    d  = out_data;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; rx_done = 1'b0; out_ready = 1'b0; rx_data = 8'h00;
    {btn_mode, btn_time, btn_run, btn_clear} = 4'b0000;
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop: got %0d want 0", drop_cnt); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency_gap();
    int lows;
    do_reset();
    out_ready = 1'b1;
    pulse_rx(8'h6D);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got %b want 0", out_valid); end
    @(negedge clk);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want 1", out_valid); end
    total++; if (out_data !== 8'h4D) begin bad++; $display("FAIL lat_data: got %h want 4d", out_data); end
    // 'M' transfers at the next edge while 'R' is sampled at that same edge.
    pulse_rx(8'h52);
    wait_valid(lows);
    total++; if (lows != 8) begin bad++; $display("FAIL gap_len: got %0d want 8", lows); end
    total++; if (out_data !== 8'h52) begin bad++; $display("FAIL gap_data: got %h want 52", out_data); end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    logic [7:0] d; logic ok;
    do_reset();
    out_ready = 1'b1;
    rx_data = 8'h48; rx_done = 1'b1; btn_run = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; btn_run = 1'b0;
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h48) begin bad++; $display("FAIL rr1_first: got %h ok=%b want 48", d, ok); end
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h52) begin bad++; $display("FAIL rr1_second: got %h ok=%b want 52", d, ok); end
    // A lone UART grant leaves the pointer on the button source.
    pulse_rx(8'h63);
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h43) begin bad++; $display("FAIL rr_single: got %h ok=%b want 43", d, ok); end
    rx_data = 8'h48; rx_done = 1'b1; btn_run = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; btn_run = 1'b0;
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h52) begin bad++; $display("FAIL rr2_first: got %h ok=%b want 52", d, ok); end
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h48) begin bad++; $display("FAIL rr2_second: got %h ok=%b want 48", d, ok); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL rr_drop: got %0d want 0", drop_cnt); end
  endtask

  task automatic test_btn_priority();
    logic [7:0] d; logic ok; int lows;
    do_reset();
    out_ready = 1'b1;
    pulse_btn(4'b1001);
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL prio_drop1: got %0d want 1", drop_cnt); end
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h4D) begin bad++; $display("FAIL prio_cmd1: got %h ok=%b want 4d", d, ok); end
    wait_valid(lows);
    total++; if (lows != WaitMax) begin bad++; $display("FAIL prio_extra: got valid after %0d want none", lows); end
    pulse_btn(4'b0111);
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL prio_drop2: got %0d want 3", drop_cnt); end
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h48) begin bad++; $display("FAIL prio_cmd2: got %h ok=%b want 48", d, ok); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] cmds [6];
    logic [7:0] exp  [5];
    logic [7:0] d; logic ok; int lows;
    cmds = '{8'h4D, 8'h48, 8'h52, 8'h43, 8'h6D, 8'h68};
    exp  = '{8'h4D, 8'h48, 8'h52, 8'h43, 8'h4D};
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) begin
        total++; if (fifo_full !== 1'b0) begin bad++; $display("FAIL full_at3: got %b want 0", fifo_full); end
      end
      if (i == 4) begin
        total++; if (fifo_full !== 1'b1) begin bad++; $display("FAIL full_at4: got %b want 1", fifo_full); end
      end
      pulse_rx(cmds[i]);
      @(negedge clk);
    end
    total++; if (drop_cnt !== 8'd1) begin bad++; $display("FAIL full_drop: got %0d want 1", drop_cnt); end
    total++; if (out_valid !== 1'b1 || out_data !== 8'h4D) begin
      bad++; $display("FAIL full_stall: got v=%b d=%h want v=1 d=4d", out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      get_cmd(d, ok);
      total++; if (!ok || d !== exp[i]) begin
        bad++; $display("FAIL drain_%0d: got %h ok=%b want %h", i, d, ok, exp[i]);
      end
    end
    wait_valid(lows);
    total++; if (lows != WaitMax) begin bad++; $display("FAIL drain_extra: got valid after %0d want none", lows); end
    total++; if (fifo_full !== 1'b0 || drop_cnt !== 8'd1) begin
      bad++; $display("FAIL drain_end: got full=%b drop=%0d want full=0 drop=1", fifo_full, drop_cnt);
    end
  endtask

  task automatic test_invalid();
    logic [7:0] d; logic ok; int lows;
    do_reset();
    out_ready = 1'b1;
    pulse_rx(8'h41);
    pulse_rx(8'h6E);
    wait_valid(lows);
    total++; if (lows != WaitMax) begin bad++; $display("FAIL inv_valid: got valid after %0d want none", lows); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL inv_drop: got %0d want 0", drop_cnt); end
    pulse_rx(8'h72);
    get_cmd(d, ok);
    total++; if (!ok || d !== 8'h52) begin bad++; $display("FAIL inv_after: got %h ok=%b want 52", d, ok); end
  endtask

  task automatic test_async_reset();
    int lows;
    do_reset();
    out_ready = 1'b0;
    pulse_btn(4'b1100);
    @(negedge clk);
    pulse_rx(8'h68);
    @(negedge clk);
    pulse_rx(8'h72);
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b1 || drop_cnt !== 8'd1) begin
      bad++; $display("FAIL ar_pre: got v=%b drop=%0d want v=1 drop=1", out_valid, drop_cnt);
    end
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got %b want 0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL ar_data: got %h want 00", out_data); end
    total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL ar_drop: got %0d want 0", drop_cnt); end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    wait_valid(lows);
    total++; if (lows != WaitMax) begin bad++; $display("FAIL ar_stale: got valid after %0d want none", lows); end
  endtask

  task automatic test_saturate();
    do_reset();
    out_ready = 1'b1;
    pulse_btn(4'b1111);
    total++; if (drop_cnt !== 8'd3) begin bad++; $display("FAIL sat_first: got %0d want 3", drop_cnt); end
    // At least three losers per pulse: 90 pulses exceed 255.
    for (int i = 0; i < 90; i++) pulse_btn(4'b1111);
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_max: got %0d want 255", drop_cnt); end
    for (int i = 0; i < 5; i++) pulse_btn(4'b1111);
    total++; if (drop_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", drop_cnt); end
  endtask

  initial begin
    test_reset();
    test_latency_gap();
    test_round_robin();
    test_btn_priority();
    test_fifo_full();
    test_invalid();
    test_async_reset();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
